// File: rtl/global_reset_gen.sv
// ---------------------------------------------------------------------------
// global_reset_gen
//   System reset generator. Asserts the system reset asynchronously as soon
//   as the reset request rises. Releases it synchronously to clk after
//   SYNC_STAGES synchronizer flops and a further HOLD_CYCLES stretch cycles.
//
//   Release timing: edge 1 is the first clk edge that samples rst_in low.
//   rst falls on edge SYNC_STAGES + HOLD_CYCLES.
//
//   Power-up state is the same as the asynchronously set state (sync chain
//   all ones, counter zero, rst=1, rst_n=0). FPGA flows should map the
//   async-set values onto the flop configuration init values.
//
// Parameters
//   SYNC_STAGES  number of release-synchronizer flops (2..8)
//   HOLD_CYCLES  clk cycles of reset stretch after sync release (0..2^24-1)
//
// Ports
//   clk     in   system clock (48 MHz nominal)
//   rst_in  in   asynchronous, active-high reset request
//   rst     out  active-high system reset, registered
//   rst_n   out  active-low system reset, registered complement of rst
// ---------------------------------------------------------------------------
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_ASSERT  | rst_in high or just released; everything held in reset
// ST_SYNC    | zeros shifting through the release synchronizer
// ST_HOLD    | synchronizer released, hold counter stretching the reset
// ST_RUN     | reset released; stays here until rst_in rises again
// ---------------------------------------------------------------------------
module global_reset_gen #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_in,
    output logic rst,
    output logic rst_n
);

    localparam int unsigned CNT_W = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_SYNC   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rst_q, rst_n_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b0};

        // Counter is held at zero while the synchronizer output is still 1,
        // then counts up and saturates so it can never wrap.
        cnt_d = cnt_q;
        if (sync_q[SYNC_STAGES-1]) begin
            cnt_d = '0;
        end else if (cnt_q != HOLD_VAL) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Next state is decided from the next-cycle chain/counter values so
        // the registered rst can drop on the exact edge the release completes.
        state_d = state_q;
        unique case (state_q)
            ST_ASSERT: state_d = ST_SYNC;
            ST_SYNC: begin
                if (!sync_d[SYNC_STAGES-1]) begin
                    state_d = (cnt_d == HOLD_VAL) ? ST_RUN : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_d == HOLD_VAL) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_ASSERT;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_ASSERT;
            sync_q  <= '1;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
            rst_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            rst_q   <= (state_d != ST_RUN);
            rst_n_q <= (state_d == ST_RUN);
        end
    end

    // Both outputs come straight from flops so they cannot glitch.
    assign rst   = rst_q;
    assign rst_n = rst_n_q;

endmodule

// File: tb/tb_global_reset_gen.sv
module tb_global_reset_gen;

    logic clk      = 1'b0;
    logic clk_run  = 1'b1;
    logic rst_in_a = 1'b0;
    logic rst_in_b = 1'b0;
    logic rst_in_c = 1'b0;
    logic rst_a, rst_n_a, rst_b, rst_n_b, rst_c, rst_n_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 if (clk_run) clk = ~clk;

    global_reset_gen #(.SYNC_STAGES(2), .HOLD_CYCLES(8)) dut_a (
        .clk(clk), .rst_in(rst_in_a), .rst(rst_a), .rst_n(rst_n_a)
    );
    global_reset_gen #(.SYNC_STAGES(3), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .rst_in(rst_in_b), .rst(rst_b), .rst_n(rst_n_b)
    );
    global_reset_gen dut_c (
        .clk(clk), .rst_in(rst_in_c), .rst(rst_c), .rst_n(rst_n_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_fall;
        int bad;
        int k;
        bit pulsed;

        // Emulated power-up: all three blocks set, then dut_a released
        // before the first clk edge at t=5.
        #1;
        rst_in_a = 1'b1;
        rst_in_b = 1'b1;
        rst_in_c = 1'b1;
        #1;
        rst_in_a = 1'b0;
        chk("pwrup_rst", 32'(rst_a), 32'd1);
        chk("pwrup_rst_n", 32'(rst_n_a), 32'd0);

        // SYNC=2, HOLD=8: rst high through edge 9, low after edge 10
        for (int e = 1; e <= 12; e++) begin
            step();
            chk($sformatf("a_rel_e%0d", e), 32'(rst_a), (e < 10) ? 32'd1 : 32'd0);
            chk($sformatf("a_rel_n_e%0d", e), 32'(rst_n_a), (e < 10) ? 32'd0 : 32'd1);
        end
        chk("a_cnt_sat", 32'(dut_a.cnt_q), 32'd8);

        // Clock stopped in RUN, rst_in raised: rst must assert with no edge
        @(negedge clk);
        #1;
        clk_run = 1'b0;
        #20;
        rst_in_a = 1'b1;
        #1;
        chk("async_rst", 32'(rst_a), 32'd1);
        chk("async_rst_n", 32'(rst_n_a), 32'd0);
        #20;
        chk("async_hold", 32'(rst_a), 32'd1);
        clk_run = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk($sformatf("held_e%0d", e), 32'(rst_a), 32'd1);
        end

        // Release, then a 1 ns pulse between edges 6 and 7: full restart
        rst_in_a = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk($sformatf("pre_pulse_e%0d", e), 32'(rst_a), 32'd1);
        end
        #1;
        rst_in_a = 1'b1;
        #1;
        rst_in_a = 1'b0;
        chk("pulse_rst", 32'(rst_a), 32'd1);
        for (int e = 1; e <= 11; e++) begin
            step();
            chk($sformatf("post_pulse_e%0d", e), 32'(rst_a), (e < 10) ? 32'd1 : 32'd0);
        end

        // SYNC=3, HOLD=0: rst falls on edge 3
        chk("b_held", 32'(rst_b), 32'd1);
        rst_in_b = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk($sformatf("b_rel_e%0d", e), 32'(rst_b), (e < 3) ? 32'd1 : 32'd0);
            chk($sformatf("b_rel_n_e%0d", e), 32'(rst_n_b), (e < 3) ? 32'd0 : 32'd1);
        end

        // Defaults: rst falls on edge 4098, counter saturates at 4096
        chk("c_held", 32'(rst_c), 32'd1);
        rst_in_c = 1'b0;
        first_fall = 0;
        for (int e = 1; e <= 4100; e++) begin
            step();
            if (rst_c == 1'b0 && first_fall == 0) first_fall = e;
        end
        chk("c_first_fall", 32'(first_fall), 32'd4098);
        chk("c_cnt", 32'(dut_c.cnt_q), 32'd4096);
        bad = 0;
        repeat (10000) begin
            step();
            if (rst_c !== 1'b0 || rst_n_c !== 1'b1 || dut_c.cnt_q != 13'd4096) bad++;
        end
        chk("c_run_stable", 32'(bad), 32'd0);
        chk("c_cnt_end", 32'(dut_c.cnt_q), 32'd4096);

        // Random rst_in activity on dut_a against an edge-count model:
        // k = edges since the last release; rst expected high while k < 10.
        k = 1000;
        for (int i = 0; i < 3000; i++) begin
            int r;
            pulsed = 1'b0;
            r = $urandom_range(0, 39);
            #1;
            if (rst_in_a) begin
                if (r < 13) rst_in_a = 1'b0;
            end else if (r == 0) begin
                rst_in_a = 1'b1;
                #1;
                chk("rand_async", 32'(rst_a), 32'd1);
            end else if (r == 1) begin
                rst_in_a = 1'b1;
                #1;
                rst_in_a = 1'b0;
                pulsed = 1'b1;
                chk("rand_pulse", 32'(rst_a), 32'd1);
            end
            step();
            if (rst_in_a) k = 0;
            else if (pulsed) k = 1;
            else if (k < 1000) k++;
            chk("rand_rst", 32'(rst_a), (k < 10) ? 32'd1 : 32'd0);
            chk("rand_rst_n", 32'(rst_n_a), (k < 10) ? 32'd0 : 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
